// File: rtl/cntr_nud.sv
// cntr_nud: parametrised up/down counter with load, enable,
// run-time wrap/saturate selection and terminal-count flags.
module cntr_nud #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] bin_count,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             at_top;
    logic             at_bot;

    assign at_top = (bin_count == MAX_VAL);
    assign at_bot = (bin_count == ZERO);

    // Terminal count: end value for the current direction.
    assign tc = up_down ? at_bot : at_top;

    // Next state; boundary tested before stepping so no internal overflow.
    always_comb begin
        cnt_nxt  = bin_count;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (load) begin
            cnt_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (!up_down) begin
                if (!at_top) begin
                    cnt_nxt = bin_count + ONE;
                end else if (sat) begin
                    sat_nxt = 1'b1;
                end else begin
                    cnt_nxt  = ZERO;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    cnt_nxt = bin_count - ONE;
                end else if (sat) begin
                    sat_nxt = 1'b1;
                end else begin
                    cnt_nxt  = MAX_VAL;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_count <= ZERO;
            wrap      <= 1'b0;
            sat_hit   <= 1'b0;
        end else begin
            bin_count <= cnt_nxt;
            wrap      <= wrap_nxt;
            sat_hit   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_cntr_nud.sv
// tb_cntr_nud: scoreboard bench for cntr_nud, one WIDTH=4/MAX=9
// instance and one full-width WIDTH=8/MAX=255 instance.
module tb_cntr_nud;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       ud;
        logic       ld;
        logic [7:0] lv;
        logic       sat;
    } stim_t;

    typedef struct {
        int tgt;
        int c4;
        bit w4;
        bit h4;
        int c8;
        bit w8;
        bit h8;
    } exp_t;

    localparam int MX4 = 9;
    localparam int MX8 = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t sa;
    stim_t sb;

    logic [3:0] cnt4;
    logic       tc4, w4, h4;
    logic [7:0] cnt8;
    logic       tc8, w8, h8;

    cntr_nud #(.WIDTH(4), .MAX_VAL(4'd9)) d4 (
        .clk(clk), .reset(sa.rst), .en(sa.en), .up_down(sa.ud),
        .load(sa.ld), .load_val(sa.lv[3:0]), .sat(sa.sat),
        .bin_count(cnt4), .tc(tc4), .wrap(w4), .sat_hit(h4)
    );

    cntr_nud #(.WIDTH(8)) d8 (
        .clk(clk), .reset(sb.rst), .en(sb.en), .up_down(sb.ud),
        .load(sb.ld), .load_val(sb.lv), .sat(sb.sat),
        .bin_count(cnt8), .tc(tc8), .wrap(w8), .sat_hit(h8)
    );

    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    int   wraps8   = 0;
    int   m4       = 0;
    int   m8       = 0;
    exp_t q[$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit r, bit e, bit u, bit l,
                                 int v, bit s);
        stim_t t;
        t.rst = r;
        t.en  = e;
        t.ud  = u;
        t.ld  = l;
        t.lv  = 8'(v);
        t.sat = s;
        return t;
    endfunction

    // Reference: plain integer arithmetic over the range 0..mx.
    function automatic void mdl(input stim_t s, input int w,
                                input int mx, inout int c,
                                output bit wr, output bit sh);
        int n;
        int lv;
        wr = 0;
        sh = 0;
        lv = int'(s.lv) % (1 << w);
        if (!s.rst) begin
            c = 0;
        end else if (s.ld) begin
            c = (lv > mx) ? mx : lv;
        end else if (s.en) begin
            n = s.ud ? c - 1 : c + 1;
            if (n < 0 || n > mx) begin
                if (s.sat) sh = 1;
                else begin
                    c  = (n + mx + 1) % (mx + 1);
                    wr = 1;
                end
            end else begin
                c = n;
            end
        end
    endfunction

    function automatic int tc_of(int c, bit ud, int mx);
        return ((ud && c == 0) || (!ud && c == mx)) ? 1 : 0;
    endfunction

    task automatic step(input stim_t a, input stim_t b);
        exp_t e;
        sa = a;
        sb = b;
        mdl(a, 4, MX4, m4, e.w4, e.h4);
        mdl(b, 8, MX8, m8, e.w8, e.h8);
        e.c4  = m4;
        e.c8  = m8;
        e.tgt = edge_n + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every registered output after its edge.
    always @(posedge clk) begin
        exp_t e;
        #3;
        if (q.size() > 0 && q[0].tgt <= edge_n) begin
            e = q.pop_front();
            chk("d4_count", int'(cnt4), e.c4);
            chk("d4_wrap", int'(w4), int'(e.w4));
            chk("d4_sat_hit", int'(h4), int'(e.h4));
            chk("d4_tc", int'(tc4), tc_of(e.c4, sa.ud, MX4));
            chk("d8_count", int'(cnt8), e.c8);
            chk("d8_wrap", int'(w8), int'(e.w8));
            chk("d8_sat_hit", int'(h8), int'(e.h8));
            chk("d8_tc", int'(tc8), tc_of(e.c8, sb.ud, MX8));
            if (w8) wraps8++;
        end
    end

    stim_t i8;
    stim_t i4;
    stim_t ra;
    stim_t rb;

    initial begin
        i8 = mk(1, 0, 0, 0, 0, 0);
        i4 = mk(1, 0, 0, 0, 0, 0);
        sa = mk(0, 0, 0, 0, 0, 0);
        sb = mk(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        repeat (2) step(mk(0, 1, 0, 1, 7, 0), mk(0, 1, 0, 0, 0, 0));
        chk("reset_count", int'(cnt4), 0);
        chk("reset_wrap", int'(w4), 0);

        repeat (9) step(mk(1, 1, 0, 0, 0, 0), i8);
        chk("up_at_9", int'(cnt4), 9);
        step(mk(1, 1, 0, 0, 0, 0), i8);
        chk("up_wrap_cnt", int'(cnt4), 0);
        chk("up_wrap_flag", int'(w4), 1);
        repeat (2) step(mk(1, 1, 0, 0, 0, 0), i8);
        chk("up_after_wrap", int'(cnt4), 2);

        step(mk(1, 0, 1, 1, 2, 0), i8);
        repeat (3) step(mk(1, 1, 1, 0, 0, 0), i8);
        chk("down_wrap_cnt", int'(cnt4), 9);
        chk("down_wrap_flag", int'(w4), 1);

        step(mk(1, 0, 1, 1, 1, 1), i8);
        repeat (3) step(mk(1, 1, 1, 0, 0, 1), i8);
        chk("down_sat_cnt", int'(cnt4), 0);
        chk("down_sat_flag", int'(h4), 1);

        step(mk(1, 1, 0, 1, 5, 0), i8);
        chk("load_over_en", int'(cnt4), 5);
        step(mk(1, 1, 0, 1, 14, 0), i8);
        chk("load_clamp", int'(cnt4), 9);
        step(mk(0, 1, 0, 1, 3, 0), i8);
        chk("reset_over_load", int'(cnt4), 0);

        step(mk(1, 0, 0, 1, 3, 0), i8);
        for (int i = 0; i < 8; i++)
            step(mk(1, (i % 2) == 0, ((i / 2) % 2) == 1, 0, 0, 0), i8);

        repeat (200) step(i4, mk(1, 1, 0, 0, 0, 0));
        chk("d8_at_200", int'(cnt8), 200);
        step(i4, mk(0, 1, 0, 0, 0, 0));
        chk("d8_mid_reset", int'(cnt8), 0);
        #5;
        wraps8 = 0;
        #1;
        repeat (256) step(i4, mk(1, 1, 0, 0, 0, 0));
        #5;
        chk("d8_full_cycle", int'(cnt8), 0);
        chk("d8_one_wrap", wraps8, 1);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra = mk(($urandom % 50) != 0, ($urandom % 4) != 0,
                    $urandom % 2, ($urandom % 10) == 0,
                    $urandom % 256, $urandom % 2);
            rb = mk(($urandom % 50) != 0, ($urandom % 4) != 0,
                    $urandom % 2, ($urandom % 10) == 0,
                    $urandom % 256, $urandom % 2);
            step(ra, rb);
        end

        repeat (3) @(posedge clk);
        #5;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
